// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: keypad, ALU and display signals of the calculator sequencer
interface calc_sequencer_if;
    logic        read_input;
    logic [3:0]  keypad_input;
    logic [2:0]  operator_input;
    logic        equal_input;
    logic        key_read;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        alu_ovf;
    logic [15:0] display_value;
    logic        error;
    modport master (
        input  read_input, keypad_input, operator_input, equal_input, alu_done, alu_result, alu_ovf,
        output key_read, alu_start, alu_op, alu_a, alu_b, display_value, error
    );
    modport slave (
        output read_input, keypad_input, operator_input, equal_input, alu_done, alu_result, alu_ovf,
        input  key_read, alu_start, alu_op, alu_a, alu_b, display_value, error
    );
endinterface

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven calculator control FSM launching an external ALU
module calc_sequencer (
    input  logic clk,
    input  logic RST,
    calc_sequencer_if.master bus
);
    localparam logic [2:0] ENTRY_A = 3'd0, ENTRY_B = 3'd1, EXEC = 3'd2, WAIT_ALU = 3'd3, RESULT = 3'd4, ERROR = 3'd5;
    logic [2:0]  state_q, state_d, op_q, op_d, key_op;
    logic [15:0] a_mag_q, a_mag_d, b_mag_q, b_mag_d, res_q, res_d, res_abs;
    logic [15:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, disp_q, disp_d, a_val_d, b_val_d;
    logic        a_neg_q, a_neg_d, b_neg_q, b_neg_d, b_has_q, b_has_d;
    logic        armed_q, armed_d, key_read_q, key_read_d, start_q, start_d, err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [19:0] a_ext, b_ext;
    logic        accept, is_eq, is_op, is_dig, is_neg, is_arith;
    // next-state: key decode, operand entry, ALU handshake and registered outputs
    always_comb begin
        key_op     = bus.operator_input;
        accept     = bus.read_input && armed_q && state_q != WAIT_ALU;
        is_eq      = bus.equal_input;
        is_op      = !is_eq && key_op != 3'b000;
        is_dig     = !is_eq && !is_op;
        is_neg     = is_op && key_op == 3'b001;
        is_arith   = is_op && (key_op == 3'b010 || key_op == 3'b011 || key_op == 3'b100);
        a_ext      = 20'(a_mag_q) * 20'd10 + 20'(bus.keypad_input);
        b_ext      = 20'(b_mag_q) * 20'd10 + 20'(bus.keypad_input);
        res_abs    = res_q[15] ? -res_q : res_q;
        armed_d    = accept ? 1'b0 : (state_q != WAIT_ALU && !bus.read_input) ? 1'b1 : armed_q;
        key_read_d = accept || (key_read_q && bus.read_input);
        state_d    = state_q;
        op_d       = op_q;
        a_mag_d    = a_mag_q;
        a_neg_d    = a_neg_q;
        b_mag_d    = b_mag_q;
        b_neg_d    = b_neg_q;
        b_has_d    = b_has_q;
        res_d      = res_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        cnt_d      = cnt_q;
        case (state_q)
            ENTRY_A: if (accept) begin
                if (is_dig && a_ext <= 20'd32767) a_mag_d = a_ext[15:0];
                if (is_neg) a_neg_d = !a_neg_q;
                if (is_arith) begin
                    op_d    = key_op;
                    b_mag_d = '0;
                    b_neg_d = 1'b0;
                    b_has_d = 1'b0;
                    state_d = ENTRY_B;
                end
            end
            ENTRY_B: if (accept) begin
                if (is_dig && b_ext <= 20'd32767) begin
                    b_mag_d = b_ext[15:0];
                    b_has_d = 1'b1;
                end
                if (is_neg) b_neg_d = !b_neg_q;
                if (is_arith && !b_has_q) op_d = key_op;
                if (is_eq) begin
                    alu_a_d = a_neg_q ? -a_mag_q : a_mag_q;
                    alu_b_d = b_neg_q ? -b_mag_q : b_mag_q;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                cnt_d   = 8'd1;
                state_d = WAIT_ALU;
            end
            WAIT_ALU: begin
                if (bus.alu_done) begin
                    res_d   = bus.alu_ovf ? res_q : bus.alu_result;
                    state_d = bus.alu_ovf ? ERROR : RESULT;
                end else if (cnt_q == 8'd255) state_d = ERROR;
                else cnt_d = cnt_q + 8'd1;
            end
            RESULT: if (accept) begin
                if (is_dig) begin
                    a_mag_d = 16'(bus.keypad_input);
                    a_neg_d = 1'b0;
                    state_d = ENTRY_A;
                end
                if (is_neg) begin
                    a_mag_d = res_abs;
                    a_neg_d = !res_q[15];
                    state_d = ENTRY_A;
                end
                if (is_arith) begin
                    a_mag_d = res_abs;
                    a_neg_d = res_q[15];
                    op_d    = key_op;
                    b_mag_d = '0;
                    b_neg_d = 1'b0;
                    b_has_d = 1'b0;
                    state_d = ENTRY_B;
                end
            end
            default: if (accept) begin
                a_mag_d = is_dig ? 16'(bus.keypad_input) : 16'd0;
                a_neg_d = 1'b0;
                b_mag_d = '0;
                b_neg_d = 1'b0;
                b_has_d = 1'b0;
                res_d   = '0;
                op_d    = '0;
                alu_a_d = '0;
                alu_b_d = '0;
                cnt_d   = '0;
                state_d = ENTRY_A;
            end
        endcase
        a_val_d = a_neg_d ? -a_mag_d : a_mag_d;
        b_val_d = b_neg_d ? -b_mag_d : b_mag_d;
        start_d = state_d == EXEC;
        err_d   = state_d == ERROR;
        disp_d  = state_d == ERROR ? 16'd0 : state_d == RESULT ? res_d : (state_d == ENTRY_B && b_has_d) ? b_val_d : a_val_d;
    end
    // state and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q    <= ENTRY_A;
            op_q       <= '0;
            a_mag_q    <= '0;
            a_neg_q    <= 1'b0;
            b_mag_q    <= '0;
            b_neg_q    <= 1'b0;
            b_has_q    <= 1'b0;
            res_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            cnt_q      <= '0;
            armed_q    <= 1'b1;
            key_read_q <= 1'b0;
            start_q    <= 1'b0;
            err_q      <= 1'b0;
            disp_q     <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_mag_q    <= a_mag_d;
            a_neg_q    <= a_neg_d;
            b_mag_q    <= b_mag_d;
            b_neg_q    <= b_neg_d;
            b_has_q    <= b_has_d;
            res_q      <= res_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            key_read_q <= key_read_d;
            start_q    <= start_d;
            err_q      <= err_d;
            disp_q     <= disp_d;
        end
    end
    assign bus.key_read      = key_read_q;
    assign bus.alu_start     = start_q;
    assign bus.alu_op        = op_q;
    assign bus.alu_a         = alu_a_q;
    assign bus.alu_b         = alu_b_q;
    assign bus.display_value = disp_q;
    assign bus.error         = err_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: scenario tasks with an ALU-launch scoreboard for calc_sequencer
module tb_calc_sequencer;
    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } alu_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   kr_rises = 0;
    int   starts = 0;
    logic kr_prev = 1'b0;
    alu_t exp_q[$];
    alu_t obs_q[$];
    calc_sequencer_if bus ();
    calc_sequencer dut (.clk(clk), .RST(rst), .bus(bus));
    always #5 clk = ~clk;
    // observe ALU launches and acknowledge edges away from the active edge
    always @(negedge clk) begin
        if (bus.alu_start) begin
            obs_q.push_back({bus.alu_op, bus.alu_a, bus.alu_b});
            starts++;
        end
        if (bus.key_read && !kr_prev) kr_rises++;
        kr_prev = bus.key_read;
    end
    task automatic press(input logic eq, input logic [2:0] op, input logic [3:0] dig);
        int i;
        @(negedge clk);
        bus.read_input = 1'b1;
        bus.equal_input = eq;
        bus.operator_input = op;
        bus.keypad_input = dig;
        i = 0;
        @(negedge clk);
        while (!bus.key_read && i < 8) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (bus.key_read !== 1'b1) begin errors++; $display("FAIL key_ack: got %b expected 1", bus.key_read); end
        bus.read_input = 1'b0;
        bus.equal_input = 1'b0;
        bus.operator_input = 3'b000;
        bus.keypad_input = 4'd0;
        @(negedge clk);
    endtask
    task automatic dig(input logic [3:0] d); press(1'b0, 3'b000, d); endtask
    task automatic opk(input logic [2:0] o); press(1'b0, o, 4'd0); endtask
    task automatic eqk(); press(1'b1, 3'b000, 4'd0); endtask
    task automatic alu_pulse(input int delay, input logic [15:0] r, input logic ovf);
        repeat (delay) @(negedge clk);
        bus.alu_done = 1'b1;
        bus.alu_result = r;
        bus.alu_ovf = ovf;
        @(negedge clk);
        bus.alu_done = 1'b0;
        bus.alu_ovf = 1'b0;
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus.key_read, bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b, bus.display_value, bus.error} !== 53'd0) begin
            errors++; $display("FAIL reset_outputs: got disp=%h err=%b expected all zero", bus.display_value, bus.error);
        end
        rst = 1'b0;
    endtask
    task automatic test_basic();
        alu_t o, e;
        int s0;
        dig(4'd1); dig(4'd2);
        checks++; if (bus.display_value !== 16'd12) begin errors++; $display("FAIL basic_disp_a: got %h expected %h", bus.display_value, 16'd12); end
        opk(3'b010);
        checks++; if (bus.display_value !== 16'd12) begin errors++; $display("FAIL basic_disp_b_empty: got %h expected %h", bus.display_value, 16'd12); end
        dig(4'd3);
        checks++; if (bus.display_value !== 16'd3) begin errors++; $display("FAIL basic_disp_b: got %h expected %h", bus.display_value, 16'd3); end
        exp_q.push_back({3'b010, 16'd12, 16'd3});
        s0 = starts;
        eqk();
        checks++;
        if (obs_q.size() == 0) begin errors++; $display("FAIL basic_launch: got no alu_start expected one"); void'(exp_q.pop_front()); end
        else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL basic_launch: got op=%b a=%h b=%h expected op=%b a=%h b=%h", o.op, o.a, o.b, e.op, e.a, e.b); end
        end
        alu_pulse(2, 16'd15, 1'b0);
        checks++; if (bus.display_value !== 16'd15) begin errors++; $display("FAIL basic_result: got %h expected %h", bus.display_value, 16'd15); end
        checks++; if (starts - s0 !== 1) begin errors++; $display("FAIL basic_start_pulses: got %0d expected 1", starts - s0); end
    endtask
    task automatic test_chain_reset();
        alu_t o, e;
        opk(3'b011);
        checks++; if (bus.display_value !== 16'd15) begin errors++; $display("FAIL chain_disp_a: got %h expected %h", bus.display_value, 16'd15); end
        dig(4'd5);
        exp_q.push_back({3'b011, 16'd15, 16'd5});
        eqk();
        checks++;
        if (obs_q.size() == 0) begin errors++; $display("FAIL chain_launch: got no alu_start expected one"); void'(exp_q.pop_front()); end
        else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL chain_launch: got op=%b a=%h b=%h expected op=%b a=%h b=%h", o.op, o.a, o.b, e.op, e.a, e.b); end
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.key_read, bus.alu_start, bus.alu_op, bus.alu_a, bus.alu_b, bus.display_value, bus.error} !== 53'd0) begin
            errors++; $display("FAIL chain_async_reset: got op=%b a=%h disp=%h expected all zero", bus.alu_op, bus.alu_a, bus.display_value);
        end
        @(negedge clk);
        rst = 1'b0;
        alu_pulse(1, 16'd99, 1'b0);
        checks++; if (bus.display_value !== 16'd0) begin errors++; $display("FAIL late_done_ignored: got %h expected %h", bus.display_value, 16'd0); end
        dig(4'd4);
        checks++; if (bus.display_value !== 16'd4) begin errors++; $display("FAIL after_reset_digit: got %h expected %h", bus.display_value, 16'd4); end
    endtask
    task automatic test_limit();
        logic [3:0] ds [6] = '{4'd3, 4'd2, 4'd7, 4'd6, 4'd7, 4'd8};
        int r0, low_bad;
        do_reset();
        r0 = kr_rises;
        low_bad = 0;
        for (int i = 0; i < 6; i++) begin
            dig(ds[i]);
            if (bus.key_read !== 1'b0) low_bad++;
        end
        checks++; if (bus.display_value !== 16'd32767) begin errors++; $display("FAIL limit_value: got %h expected %h", bus.display_value, 16'd32767); end
        checks++; if (kr_rises - r0 !== 6) begin errors++; $display("FAIL limit_acks: got %0d expected 6", kr_rises - r0); end
        checks++; if (low_bad !== 0) begin errors++; $display("FAIL limit_ack_drop: got %0d late drops expected 0", low_bad); end
    endtask
    task automatic test_hold();
        int r0, hi_bad;
        do_reset();
        r0 = kr_rises;
        hi_bad = 0;
        @(negedge clk);
        bus.read_input = 1'b1;
        bus.keypad_input = 4'd5;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.key_read !== 1'b1) hi_bad++;
        end
        bus.read_input = 1'b0;
        @(negedge clk);
        checks++; if (hi_bad !== 0) begin errors++; $display("FAIL hold_ack_high: got %0d low cycles expected 0", hi_bad); end
        checks++; if (bus.key_read !== 1'b0) begin errors++; $display("FAIL hold_ack_drop: got %b expected 0", bus.key_read); end
        checks++; if (bus.display_value !== 16'd5) begin errors++; $display("FAIL hold_value: got %h expected %h", bus.display_value, 16'd5); end
        checks++; if (kr_rises - r0 !== 1) begin errors++; $display("FAIL hold_accepts: got %0d expected 1", kr_rises - r0); end
    endtask
    task automatic test_ovf();
        alu_t o, e;
        do_reset();
        dig(4'd9); opk(3'b001);
        checks++; if (bus.display_value !== 16'hFFF7) begin errors++; $display("FAIL ovf_negate: got %h expected %h", bus.display_value, 16'hFFF7); end
        opk(3'b100); dig(4'd2);
        exp_q.push_back({3'b100, 16'hFFF7, 16'd2});
        eqk();
        checks++;
        if (obs_q.size() == 0) begin errors++; $display("FAIL ovf_launch: got no alu_start expected one"); void'(exp_q.pop_front()); end
        else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL ovf_launch: got op=%b a=%h b=%h expected op=%b a=%h b=%h", o.op, o.a, o.b, e.op, e.a, e.b); end
        end
        alu_pulse(1, 16'h1234, 1'b1);
        checks++; if ({bus.error, bus.display_value} !== {1'b1, 16'd0}) begin errors++; $display("FAIL ovf_error: got err=%b disp=%h expected err=1 disp=0000", bus.error, bus.display_value); end
        dig(4'd4);
        checks++; if ({bus.error, bus.display_value} !== {1'b0, 16'd4}) begin errors++; $display("FAIL ovf_recover: got err=%b disp=%h expected err=0 disp=0004", bus.error, bus.display_value); end
    endtask
    task automatic test_timeout();
        alu_t o, e;
        do_reset();
        dig(4'd1); opk(3'b010); dig(4'd2);
        exp_q.push_back({3'b010, 16'd1, 16'd2});
        eqk();
        checks++;
        if (obs_q.size() == 0) begin errors++; $display("FAIL timeout_launch: got no alu_start expected one"); void'(exp_q.pop_front()); end
        else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL timeout_launch: got op=%b a=%h b=%h expected op=%b a=%h b=%h", o.op, o.a, o.b, e.op, e.a, e.b); end
        end
        repeat (254) @(negedge clk);
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b expected 0", bus.error); end
        @(negedge clk);
        checks++; if ({bus.error, bus.display_value} !== {1'b1, 16'd0}) begin errors++; $display("FAIL timeout_error: got err=%b disp=%h expected err=1 disp=0000", bus.error, bus.display_value); end
        dig(4'd7);
        checks++; if ({bus.error, bus.display_value} !== {1'b0, 16'd7}) begin errors++; $display("FAIL timeout_recover: got err=%b disp=%h expected err=0 disp=0007", bus.error, bus.display_value); end
        opk(3'b010); dig(4'd1);
        exp_q.push_back({3'b010, 16'd7, 16'd1});
        eqk();
        checks++;
        if (obs_q.size() == 0) begin errors++; $display("FAIL edge_launch: got no alu_start expected one"); void'(exp_q.pop_front()); end
        else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL edge_launch: got op=%b a=%h b=%h expected op=%b a=%h b=%h", o.op, o.a, o.b, e.op, e.a, e.b); end
        end
        alu_pulse(254, 16'd8, 1'b0);
        checks++; if ({bus.error, bus.display_value} !== {1'b0, 16'd8}) begin errors++; $display("FAIL done_at_255: got err=%b disp=%h expected err=0 disp=0008", bus.error, bus.display_value); end
    endtask
    task automatic test_op_replace();
        alu_t o, e;
        do_reset();
        dig(4'd5); opk(3'b010); opk(3'b011); opk(3'b111); dig(4'd2); opk(3'b100);
        checks++; if (bus.display_value !== 16'd2) begin errors++; $display("FAIL replace_disp_b: got %h expected %h", bus.display_value, 16'd2); end
        exp_q.push_back({3'b011, 16'd5, 16'd2});
        eqk();
        checks++;
        if (obs_q.size() == 0) begin errors++; $display("FAIL replace_launch: got no alu_start expected one"); void'(exp_q.pop_front()); end
        else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL replace_launch: got op=%b a=%h b=%h expected op=%b a=%h b=%h", o.op, o.a, o.b, e.op, e.a, e.b); end
        end
        alu_pulse(0, 16'd3, 1'b0);
        checks++; if (bus.display_value !== 16'd3) begin errors++; $display("FAIL replace_result: got %h expected %h", bus.display_value, 16'd3); end
        opk(3'b001);
        checks++; if (bus.display_value !== 16'hFFFD) begin errors++; $display("FAIL result_negate: got %h expected %h", bus.display_value, 16'hFFFD); end
        dig(4'd6);
        checks++; if (bus.display_value !== 16'hFFDC) begin errors++; $display("FAIL negated_entry: got %h expected %h", bus.display_value, 16'hFFDC); end
    endtask
    initial begin
        bus.read_input = 1'b0;
        bus.keypad_input = 4'd0;
        bus.operator_input = 3'b000;
        bus.equal_input = 1'b0;
        bus.alu_done = 1'b0;
        bus.alu_result = 16'd0;
        bus.alu_ovf = 1'b0;
        test_reset();
        test_basic();
        test_chain_reset();
        test_limit();
        test_hold();
        test_ovf();
        test_timeout();
        test_op_replace();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
